// File: rtl/sram_port_ctrl_pkg.sv
// Shared types and constants for the SRAM port controller slice.
package sram_port_ctrl_pkg;

  typedef enum logic {StInit, StRun} state_e;

  localparam int unsigned RSP_DEPTH = 2;
  // Wide enough to hold 0..RSP_DEPTH
  localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response stream plus both SRAM port bundles for sram_port_ctrl.
interface sram_port_ctrl_if #(
  parameter int unsigned abits = 10,
  parameter int unsigned dbits = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [abits-1:0] req_addr;
  logic [dbits-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [dbits-1:0] rsp_rdata;
  logic             init_done;
  logic [abits-1:0] sram_a0;
  logic [dbits-1:0] sram_d0;
  logic             sram_wen0;
  logic [dbits-1:0] sram_q0;
  logic [abits-1:0] sram_a1;
  logic [dbits-1:0] sram_d1;
  logic             sram_wen1;
  logic [dbits-1:0] sram_q1;

  // Master is the environment: requester, response consumer and the SRAM macro itself
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_q0, sram_q1,
    input  req_ready, rsp_valid, rsp_rdata, init_done,
    input  sram_a0, sram_d0, sram_wen0, sram_a1, sram_d1, sram_wen1
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_q0, sram_q1,
    output req_ready, rsp_valid, rsp_rdata, init_done,
    output sram_a0, sram_d0, sram_wen0, sram_a1, sram_d1, sram_wen1
  );
endinterface

// File: rtl/sram_port_rsp_fifo.sv
// In-order response buffer, RSP_DEPTH entries; simultaneous push and pop legal at any occupancy.
module sram_port_rsp_fifo
  import sram_port_ctrl_pkg::*;
#(
  parameter int unsigned dbits = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [dbits-1:0] wdata,
  input  logic             pop,
  output logic [dbits-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = $clog2(RSP_DEPTH);

  logic [dbits-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CNT_W'(RSP_DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Drives SRAM port 0 from a valid/ready request stream; reads return via a credit-guarded FIFO.
// Define SRAM_PORT_CTRL_INIT_EN to sweep INIT_VAL through port 1 after reset.
module sram_port_ctrl
  import sram_port_ctrl_pkg::*;
#(
  parameter int unsigned      abits    = 10,
  parameter int unsigned      dbits    = 16,
  parameter logic [dbits-1:0] INIT_VAL = '0
) (
  input logic             clk,
  input logic             rst,
  sram_port_ctrl_if.slave bus
);
  logic             run;
  logic             accept, rd_acc, wr_acc, pop;
  logic             rd_inflight_q;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt, occ;
  logic             rd_credit;
  logic [abits-1:0] a0;
  logic [dbits-1:0] d0;
  logic             unused_q1;

  assign unused_q1 = ^bus.sram_q1;
  assign pop       = !fifo_empty && bus.rsp_ready;

  // Outstanding reads count against the FIFO; a same-cycle pop frees a slot for a new read
  always_comb begin
    fifo_cnt  = fifo_full ? CNT_W'(RSP_DEPTH) : (fifo_empty ? '0 : CNT_W'(1));
    occ       = fifo_cnt + CNT_W'(rd_inflight_q);
    rd_credit = (occ < CNT_W'(RSP_DEPTH)) || pop;
  end

  assign bus.req_ready = run && !rst && (bus.req_we || rd_credit);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_acc        = accept && !bus.req_we;
  assign wr_acc        = accept && bus.req_we;

  always_comb begin
    a0 = accept ? bus.req_addr : '0;
    d0 = wr_acc ? bus.req_wdata : '0;
  end

  assign bus.sram_a0   = a0;
  assign bus.sram_d0   = d0;
  assign bus.sram_wen0 = wr_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_inflight_q <= 1'b0;
    else     rd_inflight_q <= rd_acc;
  end

  sram_port_rsp_fifo #(
    .dbits(dbits)
  ) u_rsp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rd_inflight_q),
    .wdata(bus.sram_q0),
    .pop  (pop),
    .rdata(bus.rsp_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;

`ifdef SRAM_PORT_CTRL_INIT_EN
  state_e           state_q;
  logic [abits-1:0] ctr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      ctr_q   <= '0;
    end else if (state_q == StInit) begin
      ctr_q <= ctr_q + 1'b1;
      if (ctr_q == '1) state_q <= StRun;
    end
  end

  assign run           = (state_q == StRun);
  assign bus.sram_wen1 = (state_q == StInit);
  assign bus.sram_a1   = run ? '0 : ctr_q;
  assign bus.sram_d1   = run ? '0 : INIT_VAL;
`else
  logic [dbits-1:0] unused_init_val;

  assign unused_init_val = INIT_VAL;
  assign run             = 1'b1;
  assign bus.sram_wen1   = 1'b0;
  assign bus.sram_a1     = '0;
  assign bus.sram_d1     = '0;
`endif

  assign bus.init_done = run;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl with a behavioural SRAM and a response scoreboard.
`timescale 1ns/1ps
module tb_sram_port_ctrl;
  localparam int unsigned     AW    = 4;
  localparam int unsigned     DW    = 16;
  localparam int unsigned     WORDS = 1 << AW;
  localparam logic [DW-1:0]   IV    = 16'hA5C3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int unsigned   tests = 0;
  int unsigned   fails = 0;
  int unsigned   wen1_seen = 0;
  logic [DW-1:0] sram    [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] exp_q   [$];

  sram_port_ctrl_if #(.abits(AW), .dbits(DW)) bus ();

  sram_port_ctrl #(
    .abits   (AW),
    .dbits   (DW),
    .INIT_VAL(IV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_wen0) sram[bus.sram_a0] <= bus.sram_d0;
    if (bus.sram_wen1) sram[bus.sram_a1] <= bus.sram_d1;
    bus.sram_q0 <= sram[bus.sram_a0];
  end
  assign bus.sram_q1 = '0;

  always @(negedge clk) if (!rst && bus.sram_wen1) wen1_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0) begin
      fails++;
      $display("FAIL reset_rsp: got valid=%b rdata=%h, expected 0/0000", bus.rsp_valid,
               bus.rsp_rdata);
    end
    tests++;
    if (bus.sram_wen0 !== 1'b0 || bus.sram_wen1 !== 1'b0 || bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got wen0=%b wen1=%b req_ready=%b, expected 0/0/0",
               bus.sram_wen0, bus.sram_wen1, bus.req_ready);
    end
`ifdef SRAM_PORT_CTRL_INIT_EN
    tests++;
    if (bus.init_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_init_done: got %b, expected 0", bus.init_done);
    end
`else
    tests++;
    if (bus.init_done !== 1'b1) begin
      fails++;
      $display("FAIL reset_init_done: got %b, expected 1", bus.init_done);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef SRAM_PORT_CTRL_INIT_EN
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      tests++;
      if (bus.req_ready !== 1'b0 || bus.sram_wen1 !== 1'b1 || bus.sram_a1 !== AW'(i) ||
          bus.sram_d1 !== IV || bus.init_done !== 1'b0) begin
        fails++;
        $display("FAIL init_sweep[%0d]: got rdy=%b wen1=%b a1=%0d d1=%h done=%b, expected 0/1/%0d/%h/0",
                 i, bus.req_ready, bus.sram_wen1, bus.sram_a1, bus.sram_d1, bus.init_done, i, IV);
      end
    end
    @(negedge clk);
    tests++;
    if (bus.init_done !== 1'b1 || bus.sram_wen1 !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL init_end: got done=%b wen1=%b rdy=%b, expected 1/0/1", bus.init_done,
               bus.sram_wen1, bus.req_ready);
    end
    for (int i = 0; i < WORDS; i++) ref_mem[i] = IV;
`else
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.init_done !== 1'b1 || bus.sram_wen1 !== 1'b0) begin
      fails++;
      $display("FAIL no_init_first: got rdy=%b done=%b wen1=%b, expected 1/1/0", bus.req_ready,
               bus.init_done, bus.sram_wen1);
    end
`endif
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd3; bus.req_wdata = 16'hBEEF;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.sram_wen0 !== 1'b1 || bus.sram_a0 !== 4'd3 ||
        bus.sram_d0 !== 16'hBEEF) begin
      fails++;
      $display("FAIL wr_port0: got rdy=%b wen0=%b a0=%0d d0=%h, expected 1/1/3/beef",
               bus.req_ready, bus.sram_wen0, bus.sram_a0, bus.sram_d0);
    end
    ref_mem[3] = 16'hBEEF;
    tick();
    bus.req_we = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.sram_wen0 !== 1'b0 || bus.sram_a0 !== 4'd3) begin
      fails++;
      $display("FAIL rd_port0: got rdy=%b wen0=%b a0=%0d, expected 1/0/3", bus.req_ready,
               bus.sram_wen0, bus.sram_a0);
    end
    exp_q.push_back(ref_mem[3]);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_latency_early: got rsp_valid=%b at t+1, expected 0", bus.rsp_valid);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp) begin
      fails++;
      $display("FAIL rd_after_wr: got valid=%b rdata=%h at t+2, expected 1/%h", bus.rsp_valid,
               bus.rsp_rdata, exp);
    end
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_single: got rsp_valid=%b after pop, expected 0", bus.rsp_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int            issued = 0;
    int            got = 0;
    int            gaps = 0;
    int            first_c = -1;
    int            last_c = -1;
    logic [DW-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = AW'(i);
      bus.req_wdata = DW'(16'h10 + i);
      @(negedge clk);
      if (bus.req_ready === 1'b1) ref_mem[i] = DW'(16'h10 + i);
      tick();
    end
    bus.req_we = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 24 && got < 8; c++) begin
      bus.req_valid = (issued < 8);
      bus.req_addr  = AW'(issued);
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_unexpected: got rdata=%h, expected no response", bus.rsp_rdata);
        end else begin
          exp = exp_q.pop_front();
          if (bus.rsp_rdata !== exp) begin
            fails++;
            $display("FAIL b2b_data[%0d]: got %h, expected %h", got, bus.rsp_rdata, exp);
          end
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (bus.req_valid) begin
        if (bus.req_ready === 1'b1) begin
          exp_q.push_back(ref_mem[issued]);
          issued++;
        end else begin
          gaps++;
        end
      end
      tick();
    end
    bus.req_valid = 1'b0;
    tests++;
    if (got != 8 || gaps != 0 || first_c != 2 || last_c - first_c != 7) begin
      fails++;
      $display("FAIL b2b_timing: got n=%0d gaps=%0d first=%0d span=%0d, expected 8/0/2/7", got,
               gaps, first_c, last_c - first_c);
    end
  endtask

  task automatic test_backpressure();
    int            acc = 0;
    int            got = 0;
    logic [DW-1:0] exp;
    bus.rsp_ready = 1'b0;
    bus.req_we    = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(acc);
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        exp_q.push_back(ref_mem[acc]);
        acc++;
      end
      tick();
    end
    tests++;
    if (acc != 2) begin
      fails++;
      $display("FAIL bp_accepted: got %0d reads accepted, expected 2", acc);
    end
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_read_stall: got req_ready=%b, expected 0", bus.req_ready);
    end
    tick();
    bus.req_we = 1'b1; bus.req_addr = 4'd9; bus.req_wdata = 16'h1234;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.sram_wen0 !== 1'b1) begin
      fails++;
      $display("FAIL bp_write: got rdy=%b wen0=%b, expected 1/1", bus.req_ready, bus.sram_wen0);
    end
    if (bus.req_ready === 1'b1) ref_mem[9] = 16'h1234;
    tick();
    bus.req_we    = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20 && (acc < 4 || exp_q.size() > 0); c++) begin
      bus.req_valid = (acc < 4);
      bus.req_addr  = AW'(acc);
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL bp_unexpected: got rdata=%h, expected no response", bus.rsp_rdata);
        end else begin
          exp = exp_q.pop_front();
          if (bus.rsp_rdata !== exp) begin
            fails++;
            $display("FAIL bp_data[%0d]: got %h, expected %h", got, bus.rsp_rdata, exp);
          end
        end
        got++;
      end
      if (bus.req_valid && bus.req_ready === 1'b1) begin
        exp_q.push_back(ref_mem[acc]);
        acc++;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    tests++;
    if (got != 4 || acc != 4) begin
      fails++;
      $display("FAIL bp_drain: got %0d responses %0d reads, expected 4/4", got, acc);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    bus.rsp_ready = 1'b0;
    bus.req_we    = 1'b0;
    for (int c = 0; c < 6 && acc < 2; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = (acc == 0) ? 4'd9 : 4'd3;
      @(negedge clk);
      if (bus.req_ready === 1'b1) acc++;
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b1 || acc != 2) begin
      fails++;
      $display("FAIL rst_mid_setup: got rsp_valid=%b reads=%0d, expected 1/2", bus.rsp_valid, acc);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0) begin
      fails++;
      $display("FAIL rst_async: got valid=%b rdata=%h, expected 0/0000", bus.rsp_valid,
               bus.rsp_rdata);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rsp_ready = 1'b1;
`ifdef SRAM_PORT_CTRL_INIT_EN
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b0 || bus.sram_wen1 !== 1'b1 || bus.sram_a1 !== AW'(i)) begin
        fails++;
        $display("FAIL rst_resweep[%0d]: got valid=%b wen1=%b a1=%0d, expected 0/1/%0d", i,
                 bus.rsp_valid, bus.sram_wen1, bus.sram_a1, i);
      end
    end
    @(negedge clk);
    tests++;
    if (bus.init_done !== 1'b1) begin
      fails++;
      $display("FAIL rst_resweep_done: got init_done=%b, expected 1", bus.init_done);
    end
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        fails++;
        $display("FAIL rst_stale[%0d]: got valid=%b rdy=%b, expected 0/1", i, bus.rsp_valid,
                 bus.req_ready);
      end
    end
    tests++;
    if (wen1_seen != 0) begin
      fails++;
      $display("FAIL no_init_port1: got %0d cycles with wen1=1, expected 0", wen1_seen);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
